// File: rtl/alu_4_pkg.sv
// rtl/alu_4_pkg.sv - mode constants and function codes for the 4-bit 74181-style ALU
package alu_4_pkg;

   localparam logic MODE_LOGIC = 1'b1;
   localparam logic MODE_ARITH = 1'b0;

   typedef enum logic [3:0] {
      L_NOT_A     = 4'h0,
      L_NOR       = 4'h1,
      L_NOTA_AND_B = 4'h2,
      L_ZERO      = 4'h3,
      L_NAND      = 4'h4,
      L_NOT_B     = 4'h5,
      L_XOR       = 4'h6,
      L_A_AND_NOTB = 4'h7,
      L_NOTA_OR_B = 4'h8,
      L_XNOR      = 4'h9,
      L_B         = 4'hA,
      L_AND       = 4'hB,
      L_ONES      = 4'hC,
      L_A_OR_NOTB = 4'hD,
      L_OR        = 4'hE,
      L_A         = 4'hF
   } logic_op_e;

   // Names describe the X+Y operand pair before cin is added.
   typedef enum logic [3:0] {
      A_A          = 4'h0,
      A_AORB       = 4'h1,
      A_AORNB      = 4'h2,
      A_MINUS1     = 4'h3,
      A_A_P_ANB    = 4'h4,
      A_AORB_P_ANB = 4'h5,
      A_A_P_NB     = 4'h6,
      A_ANB_M1     = 4'h7,
      A_A_P_AB     = 4'h8,
      A_A_P_B      = 4'h9,
      A_AORNB_P_AB = 4'hA,
      A_AB_M1      = 4'hB,
      A_A_P_A      = 4'hC,
      A_AORB_P_A   = 4'hD,
      A_AORNB_P_A  = 4'hE,
      A_A_M1       = 4'hF
   } arith_op_e;

endpackage

// File: rtl/alu_4_if.sv
// rtl/alu_4_if.sv - operand/select/result bundle for alu_4; zero/ovf exist only with ALU4_FLAGS_EN
interface alu_4_if;
   import alu_4_pkg::*;

   logic [3:0] a;
   logic [3:0] b;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       s3;
   logic       cin;
   logic       m;
   logic [3:0] f;
   logic       cout;
`ifdef ALU4_FLAGS_EN
   logic       zero;
   logic       ovf;
`endif

`ifdef ALU4_FLAGS_EN
   modport master (output a, b, s0, s1, s2, s3, cin, m, input f, cout, zero, ovf);
   modport slave  (input a, b, s0, s1, s2, s3, cin, m, output f, cout, zero, ovf);
`else
   modport master (output a, b, s0, s1, s2, s3, cin, m, input f, cout);
   modport slave  (input a, b, s0, s1, s2, s3, cin, m, output f, cout);
`endif

endinterface

// File: rtl/alu_4_core.sv
// rtl/alu_4_core.sv - combinational function core of alu_4; ALU4_FLAGS_EN adds zero/ovf outputs
module alu_4_core
   import alu_4_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] sel,
   input  logic       cin,
   input  logic       m,
   output logic [3:0] f_next,
   output logic       cout_next
`ifdef ALU4_FLAGS_EN
   ,
   output logic       zero_next,
   output logic       ovf_next
`endif
);

   logic [3:0] logic_f;
   logic [3:0] x;
   logic [3:0] y;
   logic [4:0] sum;

   always_comb begin
      logic_f = 4'h0;
      case (sel)
         L_NOT_A:      logic_f = ~a;
         L_NOR:        logic_f = ~(a | b);
         L_NOTA_AND_B: logic_f = ~a & b;
         L_ZERO:       logic_f = 4'h0;
         L_NAND:       logic_f = ~(a & b);
         L_NOT_B:      logic_f = ~b;
         L_XOR:        logic_f = a ^ b;
         L_A_AND_NOTB: logic_f = a & ~b;
         L_NOTA_OR_B:  logic_f = ~a | b;
         L_XNOR:       logic_f = ~(a ^ b);
         L_B:          logic_f = b;
         L_AND:        logic_f = a & b;
         L_ONES:       logic_f = 4'hF;
         L_A_OR_NOTB:  logic_f = a | ~b;
         L_OR:         logic_f = a | b;
         L_A:          logic_f = a;
         default:      logic_f = 4'h0;
      endcase
   end

   // Each arithmetic function is an X+Y pair; the "minus 1" forms use Y=4'hF.
   always_comb begin
      x = a;
      y = 4'h0;
      case (sel)
         A_A:          begin x = a;      y = 4'h0;   end
         A_AORB:       begin x = a | b;  y = 4'h0;   end
         A_AORNB:      begin x = a | ~b; y = 4'h0;   end
         A_MINUS1:     begin x = 4'h0;   y = 4'hF;   end
         A_A_P_ANB:    begin x = a;      y = a & ~b; end
         A_AORB_P_ANB: begin x = a | b;  y = a & ~b; end
         A_A_P_NB:     begin x = a;      y = ~b;     end
         A_ANB_M1:     begin x = a & ~b; y = 4'hF;   end
         A_A_P_AB:     begin x = a;      y = a & b;  end
         A_A_P_B:      begin x = a;      y = b;      end
         A_AORNB_P_AB: begin x = a | ~b; y = a & b;  end
         A_AB_M1:      begin x = a & b;  y = 4'hF;   end
         A_A_P_A:      begin x = a;      y = a;      end
         A_AORB_P_A:   begin x = a | b;  y = a;      end
         A_AORNB_P_A:  begin x = a | ~b; y = a;      end
         A_A_M1:       begin x = a;      y = 4'hF;   end
         default:      begin x = a;      y = 4'h0;   end
      endcase
   end

   assign sum       = {1'b0, x} + {1'b0, y} + {4'b0, cin};
   assign f_next    = (m == MODE_LOGIC) ? logic_f : sum[3:0];
   assign cout_next = (m == MODE_LOGIC) ? 1'b0 : sum[4];

`ifdef ALU4_FLAGS_EN
   logic [3:0] low_sum;

   // low_sum[3] is the carry into bit 3.
   assign low_sum   = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, cin};
   assign zero_next = (f_next == 4'h0);
   assign ovf_next  = (m == MODE_LOGIC) ? 1'b0 : (low_sum[3] ^ sum[4]);
`endif

endmodule

// File: rtl/alu_4.sv
// rtl/alu_4.sv - 4-bit 74181-style ALU slice with registered outputs
// rtl/alu_4.sv - ALU4_FLAGS_EN adds registered zero/ovf flags
module alu_4
   import alu_4_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   alu_4_if.slave bus
);

   logic [3:0] f_next;
   logic       cout_next;
   logic [3:0] f_q;
   logic       cout_q;

`ifdef ALU4_FLAGS_EN
   logic zero_next;
   logic ovf_next;
   logic zero_q;
   logic ovf_q;
`endif

   alu_4_core u_core (
      .a         (bus.a),
      .b         (bus.b),
      .sel       ({bus.s3, bus.s2, bus.s1, bus.s0}),
      .cin       (bus.cin),
      .m         (bus.m),
      .f_next    (f_next),
      .cout_next (cout_next)
`ifdef ALU4_FLAGS_EN
      ,
      .zero_next (zero_next),
      .ovf_next  (ovf_next)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q    <= 4'h0;
         cout_q <= 1'b0;
      end else begin
         f_q    <= f_next;
         cout_q <= cout_next;
      end
   end

   assign bus.f    = f_q;
   assign bus.cout = cout_q;

`ifdef ALU4_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_next;
         ovf_q  <= ovf_next;
      end
   end

   assign bus.zero = zero_q;
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_4.sv
// tb/tb_alu_4.sv - directed and randomised self-checking bench for alu_4 (flags checked when ALU4_FLAGS_EN)
module tb_alu_4;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   alu_4_if bus ();

   alu_4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic cin, input logic m);
      bus.a   = a;
      bus.b   = b;
      {bus.s3, bus.s2, bus.s1, bus.s0} = s;
      bus.cin = cin;
      bus.m   = m;
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic cin, input logic m);
      @(negedge clk);
      drive(a, b, s, cin, m);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ref_logic(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      case (s)
         4'h0: return ~a;
         4'h1: return ~(a | b);
         4'h2: return ~a & b;
         4'h3: return 4'h0;
         4'h4: return ~(a & b);
         4'h5: return ~b;
         4'h6: return a ^ b;
         4'h7: return a & ~b;
         4'h8: return ~a | b;
         4'h9: return ~(a ^ b);
         4'hA: return b;
         4'hB: return a & b;
         4'hC: return 4'hF;
         4'hD: return a | ~b;
         4'hE: return a | b;
         default: return a;
      endcase
   endfunction

   // Returns {ovf, cout, f} for arithmetic mode, using integer sums.
   function automatic logic [5:0] ref_arith(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] s, input logic cin);
      int x, y, tot, lo;
      int ia, ib, inb;
      ia  = int'(a);
      ib  = int'(b);
      inb = 15 - ib;
      case (s)
         4'h0: begin x = ia;              y = 0;          end
         4'h1: begin x = ia | ib;         y = 0;          end
         4'h2: begin x = ia | inb;        y = 0;          end
         4'h3: begin x = 0;               y = 15;         end
         4'h4: begin x = ia;              y = ia & inb;   end
         4'h5: begin x = ia | ib;         y = ia & inb;   end
         4'h6: begin x = ia;              y = inb;        end
         4'h7: begin x = ia & inb;        y = 15;         end
         4'h8: begin x = ia;              y = ia & ib;    end
         4'h9: begin x = ia;              y = ib;         end
         4'hA: begin x = ia | inb;        y = ia & ib;    end
         4'hB: begin x = ia & ib;         y = 15;         end
         4'hC: begin x = ia;              y = ia;         end
         4'hD: begin x = ia | ib;         y = ia;         end
         4'hE: begin x = ia | inb;        y = ia;         end
         default: begin x = ia;           y = 15;         end
      endcase
      tot = x + y + int'(cin);
      lo  = (x % 8) + (y % 8) + int'(cin);
      return {1'((lo / 8) ^ (tot / 16)), 1'(tot / 16), 4'(tot % 16)};
   endfunction

   logic [3:0] logic_exp [16];
   logic [3:0] ra, rb, rs;
   logic       rc, rm;
   logic [5:0] ar;

   initial begin
      n_vec = 0;
      n_bad = 0;
      // A=1100, B=1010 gives a distinct result for every logic function.
      logic_exp = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
                    4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC};

      rst_n = 1'b1;
      drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_f", bus.f, 4'h0);
      check("rst_cout", {3'b0, bus.cout}, 4'h0);
`ifdef ALU4_FLAGS_EN
      check("rst_zero", {3'b0, bus.zero}, 4'h0);
      check("rst_ovf", {3'b0, bus.ovf}, 4'h0);
`endif

      apply(4'hF, 4'hF, 4'hC, 1'b0, 1'b1);
      check("rst_hold_f", bus.f, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      apply(4'h1, 4'h2, 4'h2, 1'b0, 1'b1);
      check("l2_f", bus.f, 4'h2);
      check("l2_cout", {3'b0, bus.cout}, 4'h0);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_f", bus.f, 4'h0);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         apply(4'hC, 4'hA, 4'(i), 1'b1, 1'b1);
         check($sformatf("logic_s%0h_f", i), bus.f, logic_exp[i]);
         check($sformatf("logic_s%0h_cout", i), {3'b0, bus.cout}, 4'h0);
      end

      apply(4'h3, 4'h5, 4'h9, 1'b0, 1'b0);
      check("add_f", bus.f, 4'h8);
      check("add_cout", {3'b0, bus.cout}, 4'h0);

      apply(4'h3, 4'h5, 4'h1, 1'b1, 1'b0);
      check("or_p1_f", bus.f, 4'h8);
      check("or_p1_cout", {3'b0, bus.cout}, 4'h0);

      apply(4'hF, 4'h1, 4'h9, 1'b0, 1'b0);
      check("wrap_f", bus.f, 4'h0);
      check("wrap_cout", {3'b0, bus.cout}, 4'h1);
`ifdef ALU4_FLAGS_EN
      check("wrap_zero", {3'b0, bus.zero}, 4'h1);
      check("wrap_ovf", {3'b0, bus.ovf}, 4'h0);
`endif

      apply(4'h7, 4'h1, 4'h9, 1'b0, 1'b0);
      check("ovf_f", bus.f, 4'h8);
      check("ovf_cout", {3'b0, bus.cout}, 4'h0);
`ifdef ALU4_FLAGS_EN
      check("ovf_ovf", {3'b0, bus.ovf}, 4'h1);
      check("ovf_zero", {3'b0, bus.zero}, 4'h0);
`endif

      apply(4'h9, 4'h6, 4'h3, 1'b0, 1'b0);
      check("m1_f", bus.f, 4'hF);
      check("m1_cout", {3'b0, bus.cout}, 4'h0);

      apply(4'h5, 4'h3, 4'h6, 1'b1, 1'b0);
      check("sub_f", bus.f, 4'h2);
      check("sub_cout", {3'b0, bus.cout}, 4'h1);

      apply(4'h3, 4'h5, 4'h6, 1'b1, 1'b0);
      check("sub_brw_f", bus.f, 4'hE);
      check("sub_brw_cout", {3'b0, bus.cout}, 4'h0);

      apply(4'h6, 4'h0, 4'hC, 1'b1, 1'b0);
      check("dbl_f", bus.f, 4'hD);
      check("dbl_cout", {3'b0, bus.cout}, 4'h0);

      apply(4'hA, 4'h3, 4'hF, 1'b0, 1'b0);
      check("a_m1_f", bus.f, 4'h9);
      check("a_m1_cout", {3'b0, bus.cout}, 4'h1);

      for (int i = 0; i < 400; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rs = 4'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         rm = 1'($urandom_range(0, 1));
         @(negedge clk);
         drive(ra, rb, rs, rc, rm);
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_f", bus.f, 4'h0);
            check("rnd_rst_cout", {3'b0, bus.cout}, 4'h0);
            #1;
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
         ar = ref_arith(ra, rb, rs, rc);
         if (rm) begin
            check($sformatf("rnd_l_a%h_b%h_s%h_f", ra, rb, rs), bus.f, ref_logic(ra, rb, rs));
            check("rnd_l_cout", {3'b0, bus.cout}, 4'h0);
         end else begin
            check($sformatf("rnd_a_a%h_b%h_s%h_c%b_f", ra, rb, rs, rc), bus.f, ar[3:0]);
            check($sformatf("rnd_a_a%h_b%h_s%h_c%b_cout", ra, rb, rs, rc), {3'b0, bus.cout}, {3'b0, ar[4]});
         end
`ifdef ALU4_FLAGS_EN
         check("rnd_zero", {3'b0, bus.zero},
               {3'b0, ((rm ? ref_logic(ra, rb, rs) : ar[3:0]) == 4'h0)});
         check("rnd_ovf", {3'b0, bus.ovf}, {3'b0, rm ? 1'b0 : ar[5]});
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
